// File: rtl/dispatch_ctrl.sv
// Instruction queue and in-order dispatch scheduler feeding the RS / LSB / ROB.
// Optional single-cycle empty-queue bypass is enabled with `define DISPATCH_BYPASS_EN.

package dispatch_ctrl_pkg;

  typedef enum logic [2:0] {
    TYPE_ALU = 3'd0,
    TYPE_BRC = 3'd1,
    TYPE_JMP = 3'd2,
    TYPE_LD  = 3'd3,
    TYPE_ST  = 3'd4
  } inst_type_e;

  typedef enum logic [5:0] {
    CODE_NOP = 6'd0,
    CODE_LUI, CODE_AUIPC, CODE_JAL, CODE_JALR,
    CODE_BEQ, CODE_BNE, CODE_BLT, CODE_BGE, CODE_BLTU, CODE_BGEU,
    CODE_LB, CODE_LH, CODE_LW, CODE_LBU, CODE_LHU,
    CODE_SB, CODE_SH, CODE_SW,
    CODE_ADDI, CODE_SLTI, CODE_SLTIU, CODE_XORI, CODE_ORI, CODE_ANDI,
    CODE_SLLI, CODE_SRLI, CODE_SRAI,
    CODE_ADD, CODE_SUB, CODE_SLL, CODE_SLT, CODE_SLTU,
    CODE_XOR, CODE_SRL, CODE_SRA, CODE_OR, CODE_AND
  } inst_code_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } iq_entry_t;

  typedef struct packed {
    inst_type_e  inst_type;
    inst_code_e  inst_code;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } dec_t;

endpackage

// RV32I field decoder; unknown encodings report the last successfully decoded type/code.
module decoder
  import dispatch_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        inst_flag,
  input  logic [31:0] inst,
  output dec_t        decoded_c,
  output logic        known_c
);

  inst_type_e  held_type;
  inst_code_e  held_code;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        alt;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign alt    = inst[30];
  assign imm_i  = {{20{inst[31]}}, inst[31:20]};
  assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u  = {inst[31:12], 12'h000};
  assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign imm_sh = {27'h0, inst[24:20]};

  always_comb begin
    decoded_c = '0;
    known_c   = 1'b0;
    if (inst_flag) begin
      known_c = 1'b1;
      case (opcode)
        7'b0110111: begin
          decoded_c.inst_type = TYPE_ALU; decoded_c.inst_code = CODE_LUI;
          decoded_c.rd = inst[11:7]; decoded_c.imm = imm_u;
        end
        7'b0010111: begin
          decoded_c.inst_type = TYPE_ALU; decoded_c.inst_code = CODE_AUIPC;
          decoded_c.rd = inst[11:7]; decoded_c.imm = imm_u;
        end
        7'b1101111: begin
          decoded_c.inst_type = TYPE_JMP; decoded_c.inst_code = CODE_JAL;
          decoded_c.rd = inst[11:7]; decoded_c.imm = imm_j;
        end
        7'b1100111: begin
          decoded_c.inst_type = TYPE_JMP; decoded_c.inst_code = CODE_JALR;
          decoded_c.rd = inst[11:7]; decoded_c.rs1 = inst[19:15]; decoded_c.imm = imm_i;
        end
        7'b1100011: begin
          decoded_c.inst_type = TYPE_BRC;
          decoded_c.rs1 = inst[19:15]; decoded_c.rs2 = inst[24:20]; decoded_c.imm = imm_b;
          case (funct3)
            3'b000:  decoded_c.inst_code = CODE_BEQ;
            3'b001:  decoded_c.inst_code = CODE_BNE;
            3'b100:  decoded_c.inst_code = CODE_BLT;
            3'b101:  decoded_c.inst_code = CODE_BGE;
            3'b110:  decoded_c.inst_code = CODE_BLTU;
            3'b111:  decoded_c.inst_code = CODE_BGEU;
            default: known_c = 1'b0;
          endcase
        end
        7'b0000011: begin
          decoded_c.inst_type = TYPE_LD;
          decoded_c.rd = inst[11:7]; decoded_c.rs1 = inst[19:15]; decoded_c.imm = imm_i;
          case (funct3)
            3'b000:  decoded_c.inst_code = CODE_LB;
            3'b001:  decoded_c.inst_code = CODE_LH;
            3'b010:  decoded_c.inst_code = CODE_LW;
            3'b100:  decoded_c.inst_code = CODE_LBU;
            3'b101:  decoded_c.inst_code = CODE_LHU;
            default: known_c = 1'b0;
          endcase
        end
        7'b0100011: begin
          decoded_c.inst_type = TYPE_ST;
          decoded_c.rs1 = inst[19:15]; decoded_c.rs2 = inst[24:20]; decoded_c.imm = imm_s;
          case (funct3)
            3'b000:  decoded_c.inst_code = CODE_SB;
            3'b001:  decoded_c.inst_code = CODE_SH;
            3'b010:  decoded_c.inst_code = CODE_SW;
            default: known_c = 1'b0;
          endcase
        end
        7'b0010011: begin
          decoded_c.inst_type = TYPE_ALU;
          decoded_c.rd = inst[11:7]; decoded_c.rs1 = inst[19:15]; decoded_c.imm = imm_i;
          case (funct3)
            3'b000: decoded_c.inst_code = CODE_ADDI;
            3'b010: decoded_c.inst_code = CODE_SLTI;
            3'b011: decoded_c.inst_code = CODE_SLTIU;
            3'b100: decoded_c.inst_code = CODE_XORI;
            3'b110: decoded_c.inst_code = CODE_ORI;
            3'b111: decoded_c.inst_code = CODE_ANDI;
            3'b001: begin decoded_c.inst_code = CODE_SLLI; decoded_c.imm = imm_sh; end
            default: begin
              decoded_c.inst_code = alt ? CODE_SRAI : CODE_SRLI;
              decoded_c.imm       = imm_sh;
            end
          endcase
        end
        7'b0110011: begin
          decoded_c.inst_type = TYPE_ALU;
          decoded_c.rd = inst[11:7]; decoded_c.rs1 = inst[19:15]; decoded_c.rs2 = inst[24:20];
          case (funct3)
            3'b000:  decoded_c.inst_code = alt ? CODE_SUB : CODE_ADD;
            3'b001:  decoded_c.inst_code = CODE_SLL;
            3'b010:  decoded_c.inst_code = CODE_SLT;
            3'b011:  decoded_c.inst_code = CODE_SLTU;
            3'b100:  decoded_c.inst_code = CODE_XOR;
            3'b101:  decoded_c.inst_code = alt ? CODE_SRA : CODE_SRL;
            3'b110:  decoded_c.inst_code = CODE_OR;
            default: decoded_c.inst_code = CODE_AND;
          endcase
        end
        default: known_c = 1'b0;
      endcase
    end
    if (!known_c) begin
      decoded_c.inst_type = held_type;
      decoded_c.inst_code = held_code;
    end
  end

  // Remember the last good decode so an illegal word still carries a sane type/code.
  always_ff @(posedge clk) begin
    if (rst) begin
      held_type <= TYPE_ALU;
      held_code <= CODE_NOP;
    end else if (rdy && known_c) begin
      held_type <= decoded_c.inst_type;
      held_code <= decoded_c.inst_code;
    end
  end

endmodule

module dispatch_ctrl
  import dispatch_ctrl_pkg::*;
#(
  parameter int unsigned IQ_ADDR_W = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        rollback,
  input  logic        if_valid,
  input  logic [31:0] if_inst,
  input  logic [31:0] if_pc,
  output logic        iq_full,
  input  logic        rob_full,
  input  logic        rs_full,
  input  logic        lsb_full,
  output logic        disp_to_rs,
  output logic        disp_to_lsb,
  output logic [2:0]  disp_type,
  output logic [5:0]  disp_code,
  output logic [4:0]  disp_rd,
  output logic [4:0]  disp_rs1,
  output logic [4:0]  disp_rs2,
  output logic [31:0] disp_imm,
  output logic [31:0] disp_pc
);

  localparam int unsigned DEPTH = 2 ** IQ_ADDR_W;
  localparam int unsigned CNT_W = IQ_ADDR_W + 1;

  iq_entry_t            queue [DEPTH];
  logic [IQ_ADDR_W-1:0] head, tail;
  logic [CNT_W-1:0]     count;

  logic        active_c, bypass_sel_c, dec_flag_c, known_c;
  logic        to_lsb_c, can_disp_c, fire_c, push_c, pop_c;
  logic [31:0] dec_inst_c, dec_pc_c;
  dec_t        dec_c;

  assign iq_full  = (count == CNT_W'(DEPTH));
  assign active_c = rdy_in && !rollback;

`ifdef DISPATCH_BYPASS_EN
  // Empty queue: decode the incoming word directly so it can dispatch this edge.
  assign bypass_sel_c = (count == '0) && if_valid && active_c;
`else
  assign bypass_sel_c = 1'b0;
`endif

  assign dec_inst_c = bypass_sel_c ? if_inst : queue[head].inst;
  assign dec_pc_c   = bypass_sel_c ? if_pc : queue[head].pc;
  assign dec_flag_c = (count != '0) || bypass_sel_c;

  decoder u_decoder (
    .clk       (clk_in),
    .rst       (rst_in),
    .rdy       (rdy_in),
    .inst_flag (dec_flag_c),
    .inst      (dec_inst_c),
    .decoded_c (dec_c),
    .known_c   (known_c)
  );

  // Illegal encodings always go to the RS regardless of the held type.
  assign to_lsb_c   = known_c && ((dec_c.inst_type == TYPE_LD) || (dec_c.inst_type == TYPE_ST));
  assign can_disp_c = dec_flag_c && !rob_full && (to_lsb_c ? !lsb_full : !rs_full);
  assign fire_c     = can_disp_c && active_c;
  assign pop_c      = fire_c && !bypass_sel_c;
  assign push_c     = if_valid && !iq_full && active_c && !(bypass_sel_c && can_disp_c);

  always_ff @(posedge clk_in) begin
    if (push_c) begin
      queue[tail] <= '{inst: if_inst, pc: if_pc};
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      disp_to_rs  <= 1'b0;
      disp_to_lsb <= 1'b0;
      disp_type   <= '0;
      disp_code   <= '0;
      disp_rd     <= '0;
      disp_rs1    <= '0;
      disp_rs2    <= '0;
      disp_imm    <= '0;
      disp_pc     <= '0;
    end else if (!rdy_in) begin
      disp_to_rs  <= 1'b0;
      disp_to_lsb <= 1'b0;
    end else if (rollback) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      disp_to_rs  <= 1'b0;
      disp_to_lsb <= 1'b0;
    end else begin
      if (push_c) tail <= tail + IQ_ADDR_W'(1);
      if (pop_c)  head <= head + IQ_ADDR_W'(1);
      if (push_c && !pop_c)      count <= count + CNT_W'(1);
      else if (!push_c && pop_c) count <= count - CNT_W'(1);
      disp_to_rs  <= fire_c && !to_lsb_c;
      disp_to_lsb <= fire_c && to_lsb_c;
      if (fire_c) begin
        disp_type <= dec_c.inst_type;
        disp_code <= dec_c.inst_code;
        disp_rd   <= dec_c.rd;
        disp_rs1  <= dec_c.rs1;
        disp_rs2  <= dec_c.rs2;
        disp_imm  <= dec_c.imm;
        disp_pc   <= dec_pc_c;
      end
    end
  end

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Directed self-checking bench for dispatch_ctrl (default build, queue path only).

module tb_dispatch_ctrl;
  import dispatch_ctrl_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, rollback, if_valid;
  logic [31:0] if_inst, if_pc;
  logic        iq_full, rob_full, rs_full, lsb_full;
  logic        disp_to_rs, disp_to_lsb;
  logic [2:0]  disp_type;
  logic [5:0]  disp_code;
  logic [4:0]  disp_rd, disp_rs1, disp_rs2;
  logic [31:0] disp_imm, disp_pc;

  int compared = 0;
  int mismatched = 0;

  dispatch_ctrl #(.IQ_ADDR_W(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rollback(rollback),
    .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc), .iq_full(iq_full),
    .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full),
    .disp_to_rs(disp_to_rs), .disp_to_lsb(disp_to_lsb),
    .disp_type(disp_type), .disp_code(disp_code),
    .disp_rd(disp_rd), .disp_rs1(disp_rs1), .disp_rs2(disp_rs2),
    .disp_imm(disp_imm), .disp_pc(disp_pc)
  );

  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_pulse(input string tag, input logic rs, input logic lsb);
    chk({tag, ".rs"}, 32'(disp_to_rs), 32'(rs));
    chk({tag, ".lsb"}, 32'(disp_to_lsb), 32'(lsb));
  endtask

  task automatic push(input logic [31:0] inst, input logic [31:0] pc);
    if_valid = 1'b1;
    if_inst  = inst;
    if_pc    = pc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    rst_in = 1'b1; rdy_in = 1'b1; rollback = 1'b0; if_valid = 1'b0;
    if_inst = '0; if_pc = '0; rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0;
    step(); step();
    chk_pulse("reset", 1'b0, 1'b0);
    chk("reset.iq_full", 32'(iq_full), 32'd0);
    chk("reset.pc", disp_pc, 32'h0);
    chk("reset.imm", disp_imm, 32'h0);
    rst_in = 1'b0;

    // addi x1,x0,5: queue write, then registered dispatch
    push(32'h0050_0093, 32'h0);
    step();
    if_valid = 1'b0;
    chk_pulse("addi.early", 1'b0, 1'b0);
    step();
    chk_pulse("addi", 1'b1, 1'b0);
    chk("addi.type", 32'(disp_type), 32'(TYPE_ALU));
    chk("addi.code", 32'(disp_code), 32'(CODE_ADDI));
    chk("addi.rd", 32'(disp_rd), 32'd1);
    chk("addi.imm", disp_imm, 32'd5);
    chk("addi.pc", disp_pc, 32'h0);
    step();
    chk_pulse("addi.once", 1'b0, 1'b0);

    // lw stalled by lsb_full blocks the younger addi
    lsb_full = 1'b1;
    push(32'h0000_A103, 32'h4);
    step();
    push(32'h0030_0193, 32'h8);
    step();
    chk_pulse("lw.stall1", 1'b0, 1'b0);
    if_valid = 1'b0;
    step();
    chk_pulse("lw.stall2", 1'b0, 1'b0);
    lsb_full = 1'b0;
    step();
    chk_pulse("lw", 1'b0, 1'b1);
    chk("lw.code", 32'(disp_code), 32'(CODE_LW));
    chk("lw.type", 32'(disp_type), 32'(TYPE_LD));
    chk("lw.rd", 32'(disp_rd), 32'd2);
    chk("lw.rs1", 32'(disp_rs1), 32'd1);
    chk("lw.pc", disp_pc, 32'h4);
    step();
    chk_pulse("addi2", 1'b1, 1'b0);
    chk("addi2.rd", 32'(disp_rd), 32'd3);
    chk("addi2.pc", disp_pc, 32'h8);
    step();
    chk_pulse("addi2.once", 1'b0, 1'b0);

    // fill all 16 slots behind rob_full, 17th dropped
    rob_full = 1'b1;
    for (int i = 0; i < 16; i++) begin
      w = (32'(i) << 20) | (32'(i + 1) << 7) | 32'h13;
      push(w, 32'h100 + 32'(4 * i));
      step();
      if (i == 14) chk("fill.not_full15", 32'(iq_full), 32'd0);
    end
    chk("fill.full16", 32'(iq_full), 32'd1);
    chk_pulse("fill.stalled", 1'b0, 1'b0);
    push(32'h0630_0F93, 32'h500);
    step();
    if_valid = 1'b0;
    chk("fill.still_full", 32'(iq_full), 32'd1);
    rob_full = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      chk_pulse($sformatf("drain%0d", i), 1'b1, 1'b0);
      chk($sformatf("drain%0d.rd", i), 32'(disp_rd), 32'(i + 1));
      chk($sformatf("drain%0d.imm", i), disp_imm, 32'(i));
      chk($sformatf("drain%0d.pc", i), disp_pc, 32'h100 + 32'(4 * i));
      if (i == 0) chk("drain.iq_full_drop", 32'(iq_full), 32'd0);
    end
    step();
    chk_pulse("drain.no17th", 1'b0, 1'b0);

    // rollback with 5 queued and a simultaneous push
    rob_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push(32'h0010_0093, 32'h600 + 32'(4 * i));
      step();
    end
    rollback = 1'b1;
    push(32'h0020_0113, 32'h700);
    step();
    rollback = 1'b0; if_valid = 1'b0; rob_full = 1'b0;
    chk_pulse("rollback", 1'b0, 1'b0);
    chk("rollback.iq_full", 32'(iq_full), 32'd0);
    step();
    chk_pulse("rollback.empty1", 1'b0, 1'b0);
    step();
    chk_pulse("rollback.empty2", 1'b0, 1'b0);

    // sw / beq / jal routing and immediates
    push(32'h0020_A223, 32'h200);
    step();
    push(32'h0000_0463, 32'h204);
    step();
    chk_pulse("sw", 1'b0, 1'b1);
    chk("sw.code", 32'(disp_code), 32'(CODE_SW));
    chk("sw.imm", disp_imm, 32'd4);
    chk("sw.rs2", 32'(disp_rs2), 32'd2);
    push(32'h0100_00EF, 32'h208);
    step();
    if_valid = 1'b0;
    chk_pulse("beq", 1'b1, 1'b0);
    chk("beq.type", 32'(disp_type), 32'(TYPE_BRC));
    chk("beq.code", 32'(disp_code), 32'(CODE_BEQ));
    chk("beq.imm", disp_imm, 32'd8);
    step();
    chk_pulse("jal", 1'b1, 1'b0);
    chk("jal.type", 32'(disp_type), 32'(TYPE_JMP));
    chk("jal.code", 32'(disp_code), 32'(CODE_JAL));
    chk("jal.imm", disp_imm, 32'd16);
    chk("jal.rd", 32'(disp_rd), 32'd1);
    chk("jal.pc", disp_pc, 32'h208);
    step();
    chk_pulse("jal.once", 1'b0, 1'b0);

    // rdy_in low freezes the queue and blocks pushes
    rob_full = 1'b1;
    push(32'h0070_0293, 32'h300);
    step();
    push(32'h0080_0313, 32'h304);
    step();
    rob_full = 1'b0; rdy_in = 1'b0;
    push(32'h0090_0393, 32'h308);
    step();
    chk_pulse("rdy.hold1", 1'b0, 1'b0);
    step();
    chk_pulse("rdy.hold2", 1'b0, 1'b0);
    rdy_in = 1'b1; if_valid = 1'b0;
    step();
    chk_pulse("rdy.resume1", 1'b1, 1'b0);
    chk("rdy.resume1.rd", 32'(disp_rd), 32'd5);
    chk("rdy.resume1.pc", disp_pc, 32'h300);
    step();
    chk_pulse("rdy.resume2", 1'b1, 1'b0);
    chk("rdy.resume2.rd", 32'(disp_rd), 32'd6);
    chk("rdy.resume2.pc", disp_pc, 32'h304);
    step();
    chk_pulse("rdy.no_third", 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
